uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver for the SoC's UART pins. It is the receive-side counterpart of the UART transmitter that drives `uart0_tx`. It samples the board-level `uart0_rx` line in the system clock domain and reassembles 8N1 frames (8E1 when parity is compiled in). Received bytes are buffered in a small FIFO and presented to the bus-side peripheral logic through a valid/ready pop interface.

## Interface
- `CLK_HZ`, default 30_000_000: `sys_clk` frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `FIFO_DEPTH`, default 16: receive FIFO entries; must be a power of two, ≥2.
- `sys_clk`  in  1: system clock; all logic is on its rising edge.
- `sys_rst_n`  in  1: asynchronous active-low reset.
- `rx`  in  1: serial line, asynchronous to `sys_clk`; idles high.
- `rd_data`  out  8: byte at the FIFO head.
- `rd_valid`  out  1: FIFO is non-empty.
- `rd_ready`  in  1: pops the head when high together with `rd_valid`.
- `frame_err`  out  1: one-cycle pulse when a stop bit is sampled low.
- `overrun`  out  1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err`  out  1: one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- Derived constants:
  - `BIT_CYC = (CLK_HZ + BAUD/2) / BAUD`, which is 260 at the defaults.
  - `HALF = BIT_CYC / 2`.
- Bit counter `cnt` is `$clog2(BIT_CYC)` bits wide.
- FSM states:
  - IDLE: on `rx_s == 0`, load `cnt = HALF-1` and go to START.
  - START: when `cnt == 0`, sample `rx_s`. A 1 is a glitch: return to IDLE with no flag. A 0 loads `cnt = BIT_CYC-1` and goes to DATA.
  - DATA: at each `cnt == 0`, shift `rx_s` into the shift register LSB-first and reload `cnt`. After 8 bits, go to PARITY if compiled in, otherwise STOP.
  - PARITY: at `cnt == 0`, compare `rx_s` with the XOR of the data bits (even parity), store the mismatch, go to STOP.
  - STOP, at `cnt == 0`:
    - `rx_s == 1` with no parity mismatch: push the byte and return to IDLE.
    - `rx_s == 1` with a parity mismatch: pulse `parity_err`, discard the byte, return to IDLE.
    - `rx_s == 0`: pulse `frame_err`, discard the byte, go to RECOVER.
  - RECOVER: wait for `rx_s == 1`, then go to IDLE. This stops a break condition from retriggering a frame on every bit.
- Push when the FIFO is full and there is no pop in the same cycle: the byte is dropped, `overrun` pulses, and FIFO contents are unchanged.
- Push and pop in the same cycle with the FIFO full: both happen, no overrun.
- Push and pop in the same cycle with the FIFO empty: the pop is not possible (`rd_valid == 0`), so only the push takes effect.
- No bypass: a byte pushed into an empty FIFO appears on `rd_valid` the following cycle.
- `rd_data` holds stable while `rd_valid && !rd_ready`.

## Timing
- Reset values:
  - Synchronizer flops: 1.
  - FSM: IDLE; `cnt`: 0; shift register: 0.
  - FIFO pointers: 0.
  - `rd_valid`, `frame_err`, `overrun`, `parity_err`: 0.
  - `rd_data`: 0 (empty-FIFO read returns the entry-0 reset value).
- Reset asserted mid-frame aborts the frame with no flags. After release the FSM waits in IDLE for the next low on `rx_s`.
- Let t0 be the first cycle with `rx_s == 0` in IDLE. The pin edge precedes t0 by 2–3 cycles because of the synchronizer.
- Sample points:
  - Start bit: t0+HALF.
  - Data bit i (0..7): t0+HALF+(i+1)·BIT_CYC.
  - Parity bit: t0+HALF+9·BIT_CYC.
  - Stop bit: t0+HALF+9·BIT_CYC, or +10·BIT_CYC with parity.
- `rd_valid` rises the cycle after the stop sample.
- Error pulses assert the cycle after the stop sample.
- Back-to-back frames with zero idle time are received: the FSM is back in IDLE about HALF cycles before the next start edge.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, frame is 8E1, `parity_err` is live, and stop is sampled 10·BIT_CYC after the start sample point.
- Not defined: PARITY state and its logic are absent, frame is 8N1, `parity_err` is constant 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`, `UART_RECOVER`).
  - Function `uart_bit_cyc(clk_hz, baud)`.
  - Constant `UART_DATA_BITS = 8`.
- Shared with the transmitter.
- Sub-module `sync_fifo`, parameterized by WIDTH and DEPTH, with push/full and pop/empty ports. It is reused by the transmitter's TX buffer.
- Synchronizer, FSM and error logic stay in `uart_rx`.

## Test plan
Bench parameters: CLK_HZ=1_000_000, BAUD=62_500, so BIT_CYC=16 and HALF=8.
- Send 0xA5 as 8N1 -> `rd_data == 0xA5` and `rd_valid` rises exactly 1+HALF+9·16 cycles after t0; no flags.
- Low glitch of 4 cycles on idle `rx` -> FSM returns to IDLE, no `rd_valid`, no flags.
- Send 0x3C with stop bit held low, then `rx` low for 40 more cycles -> one `frame_err` pulse, FIFO empty. The following good 0x55 is received correctly.
- Send 17 bytes 0x00..0x10 with `rd_ready` = 0 -> 16 bytes held, a single `overrun` pulse on the 17th. Popping returns 0x00..0x0F in order.
- FIFO full, last frame's stop sample coinciding with a pop -> no overrun, new byte lands at the tail, count stays 16.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 -> `parity_err` pulse, byte discarded. With parity bit 1 -> `rd_data == 0x07`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and bit-period helper.
// Used by both the receiver and the transmitter; no logic, no latency.
// Backpressure: not applicable.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP,
    UART_RECOVER
  } uart_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int uart_bit_cyc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with combinational head read.
// Latency: a push is visible on !empty the following cycle (no bypass).
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             full,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop_rdy && !empty;
  assign do_push = push_vld && (!full || do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_dat;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a receive FIFO.
// Latency: rd_valid rises the cycle after the stop-bit sample; error pulses likewise.
// Backpressure: none on the line; a byte arriving to a full FIFO without a pop is dropped with overrun.
import uart_pkg::*;

module uart_rx #(
  parameter int CLK_HZ     = 30_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int BIT_CYC = uart_bit_cyc(CLK_HZ, BAUD);
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int BW      = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  logic                      rx_meta, rx_s;
  uart_state_t               state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [UART_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic                      tick;
  logic                      push_vld;
  logic                      fe_d;
  logic                      fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q, par_bad_d;
  logic                      pe_d;
`endif

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    push_vld = 1'b0;
    fe_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    case (state_q)
      UART_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CNT_HALF;
          state_d = UART_START;
        end
      end
      UART_START: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else if (rx_s) state_d = UART_IDLE;
        else begin
          cnt_d   = CNT_FULL;
          bit_d   = '0;
          state_d = UART_DATA;
        end
      end
      UART_DATA: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else begin
          shreg_d = {rx_s, shreg_q[UART_DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = UART_PARITY;
`else
          if (bit_q == BIT_LAST) state_d = UART_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      UART_PARITY: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else begin
          par_bad_d = rx_s ^ (^shreg_q);
          cnt_d     = CNT_FULL;
          state_d   = UART_STOP;
        end
      end
`endif
      UART_STOP: begin
        if (!tick) cnt_d = cnt_q - CW'(1);
        else if (rx_s) begin
`ifdef UART_RX_PARITY_EN
          if (par_bad_q) pe_d = 1'b1;
          else           push_vld = 1'b1;
`else
          push_vld = 1'b1;
`endif
          state_d = UART_IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = UART_RECOVER;
        end
      end
      // Hold off until the line returns high so a break is reported once.
      UART_RECOVER: begin
        if (rx_s) state_d = UART_IDLE;
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state_q   <= UART_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      frame_err <= fe_d;
      overrun   <= push_vld && fifo_full && !(rd_ready && rd_valid);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= pe_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign rd_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .core_clk (sys_clk),
    .arst_n   (sys_rst_n),
    .push_vld (push_vld),
    .push_dat (shreg_q),
    .full     (fifo_full),
    .pop_rdy  (rd_ready),
    .pop_dat  (rd_data),
    .empty    (fifo_empty)
  );

endmodule
